button_debouncer: RTL and testbench

Conditions a raw, asynchronous push-button or switch input into clean, clock-synchronous signals. It is the stage directly upstream of the counter block. Its single-cycle `press_pulse` drives the counter's `en` input, so each physical press advances the count by exactly one. Bounce, glitches and metastability are removed here, so downstream blocks see one event per press.

---
 rtl/debounce_pkg.sv | 25 ++
 rtl/button_debouncer_if.sv | 25 ++
 rtl/sync_chain.sv | 27 ++
 rtl/button_debouncer.sv | 115 +++++++++++
 tb/tb_button_debouncer.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/debounce_pkg.sv
// Shared definitions for the button debouncer: FSM state encoding and
// parameter legality checks.
package debounce_pkg;

  localparam logic [1:0] ST_IDLE_LOW   = 2'd0;
  localparam logic [1:0] ST_CHECK_HIGH = 2'd1;
  localparam logic [1:0] ST_IDLE_HIGH  = 2'd2;
  localparam logic [1:0] ST_CHECK_LOW  = 2'd3;

  typedef enum logic [1:0] {
    IDLE_LOW   = ST_IDLE_LOW,
    CHECK_HIGH = ST_CHECK_HIGH,
    IDLE_HIGH  = ST_IDLE_HIGH,
    CHECK_LOW  = ST_CHECK_LOW
  } state_t;

  localparam int MIN_DEBOUNCE_CYCLES = 2;
  localparam int MIN_SYNC_STAGES     = 2;

  // True when both parameters are inside their legal ranges.
  function automatic bit params_legal(input int debounce_cycles, input int sync_stages);
    return (debounce_cycles >= MIN_DEBOUNCE_CYCLES) && (sync_stages >= MIN_SYNC_STAGES);
  endfunction

endpackage

// File: rtl/button_debouncer_if.sv
// Button-side signal bundle: raw input towards the debouncer, conditioned
// level, pulses and busy flag back out.
interface button_debouncer_if;
  logic btn_in;
  logic btn_level;
  logic press_pulse;
  logic release_pulse;
  logic busy;

  modport master (
    output btn_in,
    input  btn_level,
    input  press_pulse,
    input  release_pulse,
    input  busy
  );

  modport slave (
    input  btn_in,
    output btn_level,
    output press_pulse,
    output release_pulse,
    output busy
  );
endinterface

// File: rtl/sync_chain.sv
// Multi-flop synchronizer for a single asynchronous input; q is the last stage.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  // Shift the raw input one stage deeper each cycle.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  // Synchronizer flops, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= sync_d;
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/button_debouncer.sv
// Debounces a raw push-button: synchronizes it, times candidate level changes
// and emits a registered level plus one-cycle press/release pulses.
module button_debouncer
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic                clk,
  input  logic                rst,
  button_debouncer_if.slave   bus
);

  localparam int             CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (!params_legal(DEBOUNCE_CYCLES, SYNC_STAGES)) begin : g_bad_params
    $error("button_debouncer: DEBOUNCE_CYCLES and SYNC_STAGES must both be >= 2");
  end

  logic btn_sync;

  sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.btn_in),
    .q   (btn_sync)
  );

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             busy_q, busy_d;

  // Next-state, timer and output logic; the timer restarts on every state entry.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      IDLE_LOW: begin
        if (btn_sync) begin
          state_d = CHECK_HIGH;
          cnt_d   = '0;
        end
      end
      CHECK_HIGH: begin
        if (!btn_sync) begin
          state_d = IDLE_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = IDLE_HIGH;
          cnt_d   = '0;
          level_d = 1'b1;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      IDLE_HIGH: begin
        if (!btn_sync) begin
          state_d = CHECK_LOW;
          cnt_d   = '0;
        end
      end
      CHECK_LOW: begin
        if (btn_sync) begin
          state_d = IDLE_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d   = IDLE_LOW;
          cnt_d     = '0;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE_LOW;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d == CHECK_HIGH) || (state_d == CHECK_LOW);
  end

  // State, timer and output registers; reset drops any in-flight candidate.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE_LOW;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.btn_level     = level_q;
  assign bus.press_pulse   = press_q;
  assign bus.release_pulse = release_q;
  assign bus.busy          = busy_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer (D=4, S=2) with a run-length reference
// model and a few hand-computed timing pins.
module tb_button_debouncer;

  localparam int D = 4;
  localparam int S = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  button_debouncer_if bus ();

  button_debouncer #(.DEBOUNCE_CYCLES(D), .SYNC_STAGES(S)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: accepted level, run length of samples that disagree with it.
  logic [S-1:0] m_sh = '0;
  logic         m_lvl = 1'b0;
  int           m_run = 0;
  logic         m_press = 1'b0;
  logic         m_rel = 1'b0;
  logic         m_busy = 1'b0;

  int edge_n = 0;
  int press_cnt = 0;
  int release_cnt = 0;
  int last_press_edge = -1;
  int last_release_edge = -1;
  int first_busy_edge = -1;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", name, edge_n, act, exp);
    end
  endtask

  // One clock: advance the model on the edge, then compare away from the edge.
  task automatic step();
    logic smp;
    logic r_v;
    logic b_v;
    @(posedge clk);
    r_v = rst;
    b_v = bus.btn_in;
    if (r_v) begin
      m_sh = '0; m_lvl = 1'b0; m_run = 0;
      m_press = 1'b0; m_rel = 1'b0; m_busy = 1'b0;
    end else begin
      smp = m_sh[S-1];
      m_sh = {m_sh[S-2:0], b_v};
      m_press = 1'b0;
      m_rel = 1'b0;
      if (smp != m_lvl) begin
        m_run++;
        if (m_run == D + 1) begin
          m_lvl = smp;
          m_press = smp;
          m_rel = ~smp;
          m_run = 0;
        end
      end else begin
        m_run = 0;
      end
      m_busy = (m_run != 0);
    end
    edge_n++;
    #1;
    check("btn_level", int'(bus.btn_level), int'(m_lvl));
    check("press_pulse", int'(bus.press_pulse), int'(m_press));
    check("release_pulse", int'(bus.release_pulse), int'(m_rel));
    check("busy", int'(bus.busy), int'(m_busy));
    if (bus.press_pulse) begin press_cnt++; last_press_edge = edge_n; end
    if (bus.release_pulse) begin release_cnt++; last_release_edge = edge_n; end
    if (bus.busy && first_busy_edge < 0) first_busy_edge = edge_n;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  int base;
  int pc0;

  initial begin
    bus.btn_in = 1'b0;

    // Reset with the button held: outputs stay 0, one press after release.
    bus.btn_in = 1'b1;
    rst = 1'b1;
    run(2);
    check("reset_level", int'(bus.btn_level), 0);
    check("reset_busy", int'(bus.busy), 0);
    rst = 1'b0;
    base = edge_n;
    pc0 = press_cnt;
    run(12);
    check("reset_press_latency", last_press_edge - base, 7);
    check("reset_press_count", press_cnt - pc0, 1);

    // Clean release after press.
    bus.btn_in = 1'b0;
    base = edge_n;
    run(12);
    check("release_latency", last_release_edge - base, 7);
    check("release_level", int'(bus.btn_level), 0);

    // Clean press: busy from edge 3, pulse at edge 7.
    bus.btn_in = 1'b1;
    base = edge_n;
    first_busy_edge = -1;
    run(12);
    check("press_busy_start", first_busy_edge - base, 3);
    check("press_latency", last_press_edge - base, 7);
    check("press_level", int'(bus.btn_level), 1);
    bus.btn_in = 1'b0;
    run(12);

    // Bounce: high 2, low 1, then high and held.
    pc0 = press_cnt;
    bus.btn_in = 1'b1;
    run(2);
    bus.btn_in = 1'b0;
    run(1);
    bus.btn_in = 1'b1;
    base = edge_n;
    run(12);
    check("bounce_press_latency", last_press_edge - base, 7);
    check("bounce_press_count", press_cnt - pc0, 1);
    bus.btn_in = 1'b0;
    run(12);

    // Reset in the middle of a CHECK: candidate discarded.
    pc0 = press_cnt;
    bus.btn_in = 1'b1;
    run(4);
    check("midcheck_busy_before", int'(bus.busy), 1);
    rst = 1'b1;
    step();
    check("midcheck_busy_after", int'(bus.busy), 0);
    rst = 1'b0;
    bus.btn_in = 1'b0;
    run(12);
    check("midcheck_no_press", press_cnt - pc0, 0);

    // Counter integration: 5 bounced presses advance the count by 5.
    pc0 = press_cnt;
    for (int p = 0; p < 5; p++) begin
      bus.btn_in = 1'b1; run(1);
      bus.btn_in = 1'b0; run(1);
      bus.btn_in = 1'b1; run(10);
      bus.btn_in = 1'b0; run(1);
      bus.btn_in = 1'b1; run(1);
      bus.btn_in = 1'b0; run(10);
    end
    check("counter_increase", press_cnt - pc0, 5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
